// File: rtl/jpeg_pkg.sv
// jpeg_pkg
//   Shared types and helpers for the JPEG frame scheduler.
//   sched_state_t : scheduler FSM states
//   BLK_DIM       : block edge length in pixels (8)
//   level_shift   : unsigned pixel -> signed pixel (value - 128)
package jpeg_pkg;

    localparam int BLK_DIM = 8;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        SEND,
        ADV,
        MARK,
        FIN
    } sched_state_t;

    // Subtracting 128 from an 8-bit unsigned value is the same as flipping
    // the MSB and reading the result as two's complement.
    function automatic logic signed [7:0] level_shift(input logic [7:0] b);
        return $signed({~b[7], b[6:0]});
    endfunction

endpackage

// File: rtl/jpeg_row_buf.sv
// jpeg_row_buf
//   One row of an 8x8 block: an 8 x 8-bit register file.
//   Ports:
//     clk      in   clock
//     wr_en    in   write strobe
//     wr_idx   in   write slot 0..7
//     wr_data  in   write value
//     rd_idx   in   read slot 0..7 (combinational read)
//     rd_data  out  value held in slot rd_idx
module jpeg_row_buf
    import jpeg_pkg::*;
(
    input  logic       clk,
    input  logic       wr_en,
    input  logic [2:0] wr_idx,
    input  logic [7:0] wr_data,
    input  logic [2:0] rd_idx,
    output logic [7:0] rd_data
);

    logic [7:0] slot_reg [BLK_DIM];

    // Contents need no reset: every slot is rewritten before it is read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            slot_reg[wr_idx] <= wr_data;
        end
    end

    assign rd_data = slot_reg[rd_idx];

endmodule

// File: rtl/jpeg_block_sched.sv
// jpeg_block_sched
//   Frame-level sequencer: walks a raster frame buffer in 8x8 block order,
//   fetching one 8-pixel row at a time into ROWBUF and sending it to the
//   pipeline as a level-shifted 8-cycle burst once pipe_rdy is seen.
//   Optional feature: define JPEG_SCHED_RESTART_EN to request a restart
//   marker (mark_req/mark_ack) every RST_INTERVAL blocks, except after the
//   last block of a frame.
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     start               1-cycle frame start (ignored unless idle)
//     busy, done          frame in progress / 1-cycle end-of-frame pulse
//     mem_rd, mem_addr    frame memory read strobe and address
//     mem_data            pixel, valid the cycle after mem_rd
//     pipe_rdy            pipeline can take one 8-pixel row
//     pipe_ena, pipe_pixel pixel strobe and signed pixel to the pipeline
//     blk_cnt             blocks fully sent this frame
//     mark_req, mark_ack  restart-marker handshake
module jpeg_block_sched
    import jpeg_pkg::*;
#(
    parameter int IMG_W        = 64,
    parameter int IMG_H        = 64,
    parameter int ADDR_W       = 12,
    parameter int RST_INTERVAL = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               mem_rd,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [7:0]         mem_data,
    input  logic               pipe_rdy,
    output logic               pipe_ena,
    output logic signed [7:0]  pipe_pixel,
    output logic [15:0]        blk_cnt,
    output logic               mark_req,
    input  logic               mark_ack
);

    localparam int BX_N = IMG_W / BLK_DIM;
    localparam int BY_N = IMG_H / BLK_DIM;
    localparam int BX_W = (BX_N > 1) ? $clog2(BX_N) : 1;
    localparam int BY_W = (BY_N > 1) ? $clog2(BY_N) : 1;

    sched_state_t state_reg, state_next;

    logic [3:0]      col_reg;      // FETCH: 0..8 (8 = final capture), SEND: 0..7
    logic [2:0]      row_reg;
    logic [BX_W-1:0] bx_reg;
    logic [BY_W-1:0] by_reg;
    logic [15:0]     blk_cnt_reg;
    logic            rd_q_reg;     // a read was issued last cycle
    logic [2:0]      rd_idx_reg;   // slot that read lands in

    logic [15:0] blk_next;
    logic        bx_last, by_last, last_blk, mark_due;
    logic [7:0]  rd_data;
    logic [ADDR_W-1:0] addr_calc;

    assign blk_next = blk_cnt_reg + 16'd1;
    assign bx_last  = (bx_reg == BX_W'(BX_N - 1));
    assign by_last  = (by_reg == BY_W'(BY_N - 1));
    assign last_blk = (row_reg == 3'd7) && bx_last && by_last;

`ifdef JPEG_SCHED_RESTART_EN
    logic unused_cfg;
    assign unused_cfg = 1'b0;
    assign mark_due = (row_reg == 3'd7) && !last_blk &&
                      ((blk_next % 16'(RST_INTERVAL)) == 16'd0);
`else
    // Restart markers compiled out: interval and acknowledge have no effect.
    logic unused_cfg;
    assign unused_cfg = mark_ack ^ (RST_INTERVAL == 0);
    assign mark_due   = 1'b0;
`endif

    assign addr_calc = (ADDR_W'(by_reg) * ADDR_W'(BLK_DIM) + ADDR_W'(row_reg)) * ADDR_W'(IMG_W)
                     + ADDR_W'(bx_reg) * ADDR_W'(BLK_DIM) + ADDR_W'(col_reg[2:0]);

    jpeg_row_buf ROWBUF (
        .clk     (clk),
        .wr_en   (rd_q_reg),
        .wr_idx  (rd_idx_reg),
        .wr_data (mem_data),
        .rd_idx  (col_reg[2:0]),
        .rd_data (rd_data)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (start)              state_next = FETCH;
            FETCH: if (col_reg == 4'd8)    state_next = WAIT;
            WAIT:  if (pipe_rdy)           state_next = SEND;
            SEND:  if (col_reg == 4'd7)    state_next = ADV;
            ADV: begin
                if (last_blk)              state_next = FIN;
                else if (mark_due)         state_next = MARK;
                else                       state_next = FETCH;
            end
            MARK:  if (mark_ack)           state_next = FETCH;
            FIN:                           state_next = IDLE;
            default:                       state_next = IDLE;
        endcase
    end

    // Outputs; all are decoded from state so an asynchronous reset clears
    // them immediately without waiting for a clock.
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        mem_rd   = 1'b0;
        pipe_ena = 1'b0;
        mark_req = 1'b0;
        case (state_reg)
            FETCH: begin
                busy   = 1'b1;
                mem_rd = (col_reg < 4'd8);
            end
            WAIT, ADV: busy = 1'b1;
            SEND: begin
                busy     = 1'b1;
                pipe_ena = 1'b1;
            end
            MARK: begin
                busy = 1'b1;
`ifdef JPEG_SCHED_RESTART_EN
                mark_req = 1'b1;
`endif
            end
            FIN:     done = 1'b1;
            default: ;
        endcase
    end

    assign mem_addr   = mem_rd ? addr_calc : '0;
    assign pipe_pixel = pipe_ena ? level_shift(rd_data) : 8'sd0;
    assign blk_cnt    = blk_cnt_reg;

    // Position counters and read-capture pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_reg     <= '0;
            row_reg     <= '0;
            bx_reg      <= '0;
            by_reg      <= '0;
            blk_cnt_reg <= '0;
            rd_q_reg    <= 1'b0;
            rd_idx_reg  <= '0;
        end else begin
            rd_q_reg   <= mem_rd;
            rd_idx_reg <= col_reg[2:0];
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        col_reg     <= '0;
                        row_reg     <= '0;
                        bx_reg      <= '0;
                        by_reg      <= '0;
                        blk_cnt_reg <= '0;
                    end
                end
                FETCH: col_reg <= (col_reg == 4'd8) ? 4'd0 : col_reg + 4'd1;
                SEND:  col_reg <= col_reg + 4'd1;
                ADV: begin
                    col_reg <= '0;
                    if (row_reg == 3'd7) begin
                        row_reg     <= '0;
                        blk_cnt_reg <= blk_next;
                        if (bx_last) begin
                            bx_reg <= '0;
                            by_reg <= by_last ? '0 : by_reg + 1'b1;
                        end else begin
                            bx_reg <= bx_reg + 1'b1;
                        end
                    end else begin
                        row_reg <= row_reg + 3'd1;
                    end
                end
                default: col_reg <= '0;
            endcase
        end
    end

endmodule
